// File: rtl/cnn_kb_pkg.sv
// -----------------------------------------------------------------------------
// cnn_kb_pkg
// Shared types and helpers for the CNN kernel/bias ping-pong bank.
//   kb_state_e     : per-channel clear engine state
//   kb_addr_width  : word address width for a bank of a given depth
//   kb_lane_width  : element-lane select width inside one RAM word
//   kb_lsb         : bit offset of channel slice c in a flattened port vector
//                    (channel 0 occupies the least-significant slice)
// -----------------------------------------------------------------------------
package cnn_kb_pkg;

  typedef enum logic [0:0] {
    KB_IDLE  = 1'b0,
    KB_CLEAR = 1'b1
  } kb_state_e;

  function automatic int kb_addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int kb_lane_width(input int data_width, input int elem_width);
    return $clog2(data_width / elem_width);
  endfunction

  function automatic int kb_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cnn_kb_channel.sv
// -----------------------------------------------------------------------------
// cnn_kb_channel
// One channel of the kernel/bias store: two inferred RAM banks, a clear engine
// that zeroes the shadow bank, the write/drop path and a 2-stage element read.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   active_bank_i        bank currently read by compute; the other is shadow
//   wenable_i            write strobe into the shadow bank
//   waddress_i/wdata_i   write word address and data
//   clear_i              start zeroing the shadow bank
//   rd_valid_i/rd_ptr_i  element read request (pointer = {word, lane})
//   rd_valid_o           read result valid (2 cycles after request)
//   rd_word_o/rd_elem_o  addressed word and selected element (held when idle)
//   clear_busy_o         clear engine running
//   wdrop_o              write was dropped during a clear (1-cycle pulse)
// -----------------------------------------------------------------------------
module cnn_kb_channel
  import cnn_kb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ELEM_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = kb_addr_width(DEPTH),
  parameter int LANE_WIDTH = kb_lane_width(DATA_WIDTH, ELEM_WIDTH),
  parameter int PTR_WIDTH  = ADDR_WIDTH + LANE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  active_bank_i,
  input  logic                  wenable_i,
  input  logic [ADDR_WIDTH-1:0] waddress_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  clear_i,
  input  logic                  rd_valid_i,
  input  logic [PTR_WIDTH-1:0]  rd_ptr_i,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_word_o,
  output logic [ELEM_WIDTH-1:0] rd_elem_o,
  output logic                  clear_busy_o,
  output logic                  wdrop_o
);

  localparam int LANES = DATA_WIDTH / ELEM_WIDTH;

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  kb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy;

  assign busy = (state_q == KB_CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      KB_IDLE: begin
        if (clear_i) begin
          state_d = KB_CLEAR;
          cnt_d   = '0;
        end
      end
      KB_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = KB_IDLE;
        end
      end
      default: state_d = KB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= KB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write mux: the clear engine owns the write port while busy, and any host
  // write arriving then is discarded and flagged.
  // ---------------------------------------------------------------------------
  logic                  shadow_bank;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wdrop_q, wdrop_d;

  assign shadow_bank = ~active_bank_i;
  assign wr_en       = busy | wenable_i;
  assign wr_addr     = busy ? cnt_q : waddress_i;
  assign wr_data     = busy ? '0 : wdata_i;
  assign wdrop_d     = busy & wenable_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdrop_q <= 1'b0;
    end else begin
      wdrop_q <= wdrop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. Stage 1 captures the pointer and the bank that was active
  // at issue, so a swap landing in between does not redirect an in-flight read.
  // ---------------------------------------------------------------------------
  logic                  rd_v1_q, rd_v2_q;
  logic [ADDR_WIDTH-1:0] addr1_q;
  logic [LANE_WIDTH-1:0] lane1_q, lane2_q;
  logic                  bank1_q, bank2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_v1_q <= 1'b0;
      addr1_q <= '0;
      lane1_q <= '0;
      bank1_q <= 1'b0;
      rd_v2_q <= 1'b0;
      lane2_q <= '0;
      bank2_q <= 1'b0;
    end else begin
      rd_v1_q <= rd_valid_i;
      if (rd_valid_i) begin
        addr1_q <= rd_ptr_i[PTR_WIDTH-1:LANE_WIDTH];
        lane1_q <= rd_ptr_i[LANE_WIDTH-1:0];
        bank1_q <= active_bank_i;
      end
      rd_v2_q <= rd_v1_q;
      // Lane and bank select only move with valid data so idle outputs hold.
      if (rd_v1_q) begin
        lane2_q <= lane1_q;
        bank2_q <= bank1_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Two banks, each a simple dual-port RAM with a registered read port.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] bank_rdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic BANK_ID = (gi == 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
      if (wr_en && (shadow_bank == BANK_ID)) begin
        mem[wr_addr] <= wr_data;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdata_q <= '0;
      end else if (rd_v1_q && (bank1_q == BANK_ID)) begin
        rdata_q <= mem[addr1_q];
      end
    end

    assign bank_rdata[gi] = rdata_q;
  end

  assign rd_word_o = bank_rdata[bank2_q];

  // Lane 0 sits in the least-significant bits of the word.
  logic [ELEM_WIDTH-1:0] lane_elem [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_elem[gi] = rd_word_o[gi*ELEM_WIDTH +: ELEM_WIDTH];
  end

  assign rd_elem_o    = lane_elem[lane2_q];
  assign rd_valid_o   = rd_v2_q;
  assign clear_busy_o = busy;
  assign wdrop_o      = wdrop_q;

endmodule

// File: rtl/cnn_kernel_bias_bank.sv
// -----------------------------------------------------------------------------
// cnn_kernel_bias_bank
// Multi-channel double-buffered kernel/bias store. Host writes and clears go to
// each channel's shadow bank while compute reads the active bank; a global
// swap handshake exchanges the banks on all channels at once.
// Ports:
//   i_clock, i_reset        clock, asynchronous active-low reset
//   i_wenable/i_waddress/i_wdata  per-channel shadow write (slice c = channel c)
//   i_clear                 per-channel clear start pulse
//   i_swap_req              swap request pulse (merged while pending)
//   i_rd_valid/i_rd_ptr     per-channel element read request
//   o_rd_valid/o_rd_word/o_rd_elem  per-channel read result (latency 2)
//   o_clear_busy            per-channel clear in progress
//   o_wdrop                 per-channel dropped-write pulse
//   o_swap_pending          swap accepted but waiting for clears to finish
//   o_swap_ack              pulse on the cycle the new active bank appears
//   o_active_bank           active bank index shared by all channels
// -----------------------------------------------------------------------------
module cnn_kernel_bias_bank
  import cnn_kb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ELEM_WIDTH = 8,
  parameter int CH_NUM     = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = kb_addr_width(DEPTH),
  parameter int LANE_WIDTH = kb_lane_width(DATA_WIDTH, ELEM_WIDTH),
  parameter int PTR_WIDTH  = ADDR_WIDTH + LANE_WIDTH
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [CH_NUM-1:0]            i_wenable,
  input  logic [CH_NUM*ADDR_WIDTH-1:0] i_waddress,
  input  logic [CH_NUM*DATA_WIDTH-1:0] i_wdata,
  input  logic [CH_NUM-1:0]            i_clear,
  input  logic                         i_swap_req,
  input  logic [CH_NUM-1:0]            i_rd_valid,
  input  logic [CH_NUM*PTR_WIDTH-1:0]  i_rd_ptr,
  output logic [CH_NUM-1:0]            o_rd_valid,
  output logic [CH_NUM*DATA_WIDTH-1:0] o_rd_word,
  output logic [CH_NUM*ELEM_WIDTH-1:0] o_rd_elem,
  output logic [CH_NUM-1:0]            o_clear_busy,
  output logic [CH_NUM-1:0]            o_wdrop,
  output logic                         o_swap_pending,
  output logic                         o_swap_ack,
  output logic                         o_active_bank
);

  // ---------------------------------------------------------------------------
  // Swap control. A pending swap waits until no channel is clearing, so a
  // half-zeroed bank never becomes active. Requests arriving while one is
  // pending (including in the apply cycle) fold into that same swap.
  // ---------------------------------------------------------------------------
  logic              active_q, active_d;
  logic              pending_q, pending_d;
  logic              ack_q, ack_d;
  logic              apply;
  logic [CH_NUM-1:0] busy;

  assign apply = pending_q & ~(|busy);

  always_comb begin
    active_d  = active_q;
    pending_d = pending_q | i_swap_req;
    ack_d     = 1'b0;
    if (apply) begin
      active_d  = ~active_q;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      active_q  <= 1'b0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      active_q  <= active_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
    end
  end

  assign o_swap_pending = pending_q;
  assign o_swap_ack     = ack_q;
  assign o_active_bank  = active_q;
  assign o_clear_busy   = busy;

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    cnn_kb_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .ELEM_WIDTH (ELEM_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LANE_WIDTH (LANE_WIDTH),
      .PTR_WIDTH  (PTR_WIDTH)
    ) u_channel (
      .clk_i         (i_clock),
      .rst_ni        (i_reset),
      .active_bank_i (active_q),
      .wenable_i     (i_wenable[gi]),
      .waddress_i    (i_waddress[kb_lsb(gi, ADDR_WIDTH) +: ADDR_WIDTH]),
      .wdata_i       (i_wdata[kb_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
      .clear_i       (i_clear[gi]),
      .rd_valid_i    (i_rd_valid[gi]),
      .rd_ptr_i      (i_rd_ptr[kb_lsb(gi, PTR_WIDTH) +: PTR_WIDTH]),
      .rd_valid_o    (o_rd_valid[gi]),
      .rd_word_o     (o_rd_word[kb_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
      .rd_elem_o     (o_rd_elem[kb_lsb(gi, ELEM_WIDTH) +: ELEM_WIDTH]),
      .clear_busy_o  (busy[gi]),
      .wdrop_o       (o_wdrop[gi])
    );
  end

endmodule
